// File: rtl/jaxa_pio_pkg.sv
// jaxa_pio_pkg: register map and edge-type encodings shared by the activity PIO.
package jaxa_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA  = 2'd0,
        ADDR_MASK  = 2'd1,
        ADDR_EDGE  = 2'd2,
        ADDR_COUNT = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/jaxa_sync_edge.sv
// jaxa_sync_edge: multi-flop synchroniser on asynchronous activity lines plus per-bit edge detector.
module jaxa_sync_edge
    import jaxa_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_data_sync,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_data_sync = r_sync[SYNC_STAGES-1];

    // prev and data_sync both reset to 0, so no edge fires in the first cycle after release
    assign o_edge = (EDGE_TYPE == EDGE_ANY)     ? (o_data_sync ^ r_prev) :
                    (EDGE_TYPE == EDGE_FALLING) ? (~o_data_sync & r_prev) :
                                                  (o_data_sync & ~r_prev);

endmodule

// File: rtl/jaxa_activity_pio.sv
// jaxa_activity_pio: Avalon-MM input port with sticky edge capture, saturating event counter
// and maskable level interrupt for SpaceWire link-activity lines.
module jaxa_activity_pio
    import jaxa_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int CNT_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0]     w_data_sync, w_edge, w_wdata, w_cap_next, w_mask_next;
    logic [WIDTH-1:0]     r_cap, r_mask;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                 w_wr, w_any;

    jaxa_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_in        (in_port),
        .o_data_sync (w_data_sync),
        .o_edge      (w_edge)
    );

    assign w_wr    = chipselect && !write_n;
    assign w_wdata = WIDTH'(writedata);
    assign w_any   = |w_edge;

    always_comb begin
        w_mask_next = (w_wr && address == ADDR_MASK) ? w_wdata : r_mask;
        // a new edge overrides a simultaneous write-1-to-clear of the same bit
        w_cap_next  = (r_cap & ~((w_wr && address == ADDR_EDGE) ? w_wdata : '0)) | w_edge;
        w_cnt_next  = (w_wr && address == ADDR_COUNT) ? CNT_WIDTH'(w_any) :
                      (w_any && r_cnt != '1)          ? r_cnt + 1'b1 : r_cnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap    <= '0;
            r_mask   <= '0;
            r_cnt    <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            r_cap    <= w_cap_next;
            r_mask   <= w_mask_next;
            r_cnt    <= w_cnt_next;
            irq      <= |(w_cap_next & w_mask_next);
            readdata <= (address == ADDR_DATA) ? 32'(w_data_sync) :
                        (address == ADDR_MASK) ? 32'(r_mask) :
                        (address == ADDR_EDGE) ? 32'(r_cap) : 32'(r_cnt);
        end
    end

endmodule

// File: tb/tb_jaxa_activity_pio.sv
// tb_jaxa_activity_pio: directed scoreboard bench over three parameterisations of the activity PIO.
module tb_jaxa_activity_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in0 = '0, in1 = '0, in2 = '0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    logic [32:0] exp_q[$];
    int          sel_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    jaxa_activity_pio u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0)
    );

    jaxa_activity_pio #(.CNT_WIDTH(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1)
    );

    jaxa_activity_pio #(.EDGE_TYPE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2)
    );

    task automatic push(input int sel, input string tag, input logic [31:0] rd, input logic ir);
        exp_q.push_back({ir, rd});
        sel_q.push_back(sel);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        logic [32:0] e, obs;
        int          s;
        string       t;
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        t = tag_q.pop_front();
        obs = (s == 0) ? {irq0, rd0} : (s == 1) ? {irq1, rd1} : {irq2, rd2};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed irq/rd=%h expected irq/rd=%h", t, obs, e);
        end
    endtask

    task automatic chk_now(input int sel, input string tag, input logic [31:0] rd, input logic ir);
        push(sel, tag, rd, ir);
        pop_check();
    endtask

    task automatic cyc(input int sel, input string tag, input logic [31:0] rd, input logic ir);
        push(sel, tag, rd, ir);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic wr(input int sel, input string tag, input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input logic ir);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc(sel, tag, rd, ir);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // reset state at every address
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            cyc(0, "reset_read", 32'h0, 1'b0);
        end

        // rising edges on bits 0 and 2, capture visible via registered read
        address = 2'd2;
        in0 = 8'h05;
        cyc(0, "cap_lat_c1", 32'h0, 1'b0);
        cyc(0, "cap_lat_c2", 32'h0, 1'b0);
        cyc(0, "cap_lat_c3", 32'h0, 1'b0);
        cyc(0, "cap_set", 32'h05, 1'b0);
        address = 2'd0;
        cyc(0, "data_read", 32'h05, 1'b0);
        address = 2'd3;
        cyc(0, "count_one", 32'h1, 1'b0);

        // mask in bit 2, then clear it
        wr(0, "mask_wr_irq", 2'd1, 32'hFFFF_FF04, 32'h0, 1'b1);
        cyc(0, "mask_read", 32'h04, 1'b1);
        wr(0, "cap_clr_irq", 2'd2, 32'h04, 32'h05, 1'b0);
        cyc(0, "cap_after_clr", 32'h01, 1'b0);

        // clear of bit 0 coincides with a fresh rising edge on bit 0
        in0 = 8'h04;
        cyc(0, "fall_no_cap_1", 32'h01, 1'b0);
        cyc(0, "fall_no_cap_2", 32'h01, 1'b0);
        cyc(0, "fall_no_cap_3", 32'h01, 1'b0);
        in0 = 8'h05;
        cyc(0, "rise_wait_1", 32'h01, 1'b0);
        cyc(0, "rise_wait_2", 32'h01, 1'b0);
        wr(0, "set_wins_wr", 2'd2, 32'h01, 32'h01, 1'b0);
        cyc(0, "set_wins", 32'h01, 1'b0);
        address = 2'd3;
        cyc(0, "count_two", 32'h2, 1'b0);

        // saturating 4-bit counter
        do_reset();
        for (int i = 0; i < 20; i++) begin
            in1 = 8'h01;
            idle(1);
            in1 = 8'h00;
            idle(1);
        end
        idle(4);
        address = 2'd3;
        cyc(1, "cnt_saturated", 32'hF, 1'b0);
        in1 = 8'h01;
        cyc(1, "cnt_hold_1", 32'hF, 1'b0);
        cyc(1, "cnt_hold_2", 32'hF, 1'b0);
        wr(1, "cnt_clr_edge_wr", 2'd3, 32'h0, 32'hF, 1'b0);
        cyc(1, "cnt_clr_edge", 32'h1, 1'b0);
        wr(1, "cnt_clr_wr", 2'd3, 32'h0, 32'h1, 1'b0);
        cyc(1, "cnt_clr", 32'h0, 1'b0);

        // any-edge detection on bit 7
        do_reset();
        in2 = 8'h80;
        idle(4);
        in2 = 8'h00;
        idle(4);
        address = 2'd3;
        cyc(2, "any_count", 32'h2, 1'b0);
        address = 2'd2;
        cyc(2, "any_cap", 32'h80, 1'b0);
        wr(2, "any_mask_wr", 2'd1, 32'h80, 32'h0, 1'b1);
        cyc(2, "any_mask_read", 32'h80, 1'b1);

        // asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        chk_now(2, "async_rst_dut2", 32'h0, 1'b0);
        chk_now(0, "async_rst_dut0", 32'h0, 1'b0);
        idle(2);
        reset_n = 1'b1;
        address = 2'd2;
        cyc(2, "post_rst_cap_1", 32'h0, 1'b0);
        cyc(2, "post_rst_cap_2", 32'h0, 1'b0);
        cyc(2, "post_rst_cap_3", 32'h0, 1'b0);
        address = 2'd3;
        cyc(2, "post_rst_cnt", 32'h0, 1'b0);
        address = 2'd1;
        cyc(2, "post_rst_mask", 32'h0, 1'b0);
        address = 2'd0;
        cyc(2, "post_rst_data", 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jaxa_activity_pio.md
Name: jaxa_activity_pio

Overview:
Parametrised Avalon-MM input port that monitors WIDTH SpaceWire link-activity/status lines.
- Synchronises the asynchronous inputs and latches edges per channel into sticky capture bits.
- Counts detected edge events and raises a maskable interrupt.
- Sits in the Qsys system beside the JAXA SpaceWire codec; the Nios firmware reads it to observe receive activity without polling every cycle.

Parameters:
WIDTH, 8, number of monitored input channels (1..32)
SYNC_STAGES, 2, flip-flop synchroniser depth on in_port (2..4)
EDGE_TYPE, 0, edge detected: 0 rising, 1 falling, 2 any
CNT_WIDTH, 16, width of saturating event counter (1..32)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  Avalon word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
in_port  input  WIDTH  asynchronous activity lines
readdata  output  32  registered read data
irq  output  1  level interrupt to CPU

Behaviour:
Clock and reset:
- Single clock clk.
- Reset reset_n is asynchronous, active-low.
- On reset: all synchroniser flops, previous-sample register, edge_capture, irq_mask, counter and readdata go to 0; irq goes to 0.

Input synchronisation and edge detection:
- in_port passes through SYNC_STAGES flops; the last stage is data_sync.
- prev holds data_sync delayed by 1 cycle.
- edge[i] by EDGE_TYPE: rising = data_sync & ~prev; falling = ~data_sync & prev; any = data_sync ^ prev.
- Latency from in_port transition to edge_capture set: SYNC_STAGES+1 cycles.

Register map (readdata is updated every cycle, 1-cycle registered read latency, bits above field width read 0):
- Addr 0 DATA, read-only: data_sync, zero-extended. Writes are ignored.
- Addr 1 IRQ_MASK, R/W: bits [WIDTH-1:0]; upper writedata bits are ignored.
- Addr 2 EDGE_CAPTURE, R/W1C: writing 1 to bit i clears edge_capture[i].
- Addr 3 EVENT_COUNT, R/W: any write clears the counter.

Write qualifier: a write happens when chipselect && !write_n.

Edge capture:
- edge_capture[i] sets when edge[i]=1.
- If edge[i] and a clear of bit i occur in the same cycle, set wins: the bit stays 1.

Event counter:
- Increments by 1 in any cycle with |edge (one count per cycle, regardless of how many channels fired).
- Saturates at all-ones and does not wrap.
- Write to addr 3 together with |edge in the same cycle: counter becomes 1.

Interrupt:
- irq is registered: irq <= |(edge_capture_next & irq_mask_next).
- irq asserts 1 cycle after the capture bit sets while masked-in.
- irq deasserts 1 cycle after the last enabled capture bit is cleared or masked off.

Mid-operation reset: asynchronous clear of all state; no edges are detected in the first cycle after release, because prev and data_sync are both 0.

Decomposition:
- Shared package jaxa_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_COUNT=3;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
- One sub-module is natural: jaxa_sync_edge, parametrised by WIDTH, SYNC_STAGES and EDGE_TYPE, containing the synchroniser plus edge detector and outputting data_sync and edge. The top level holds the registers, counter, read mux and irq.

Test Plan:
1. Reset then idle, in_port=0 -> readdata=0 at every address, irq=0, counter=0.
2. WIDTH=8, EDGE_TYPE=0: drive in_port=8'h05 -> edge_capture=0x05 exactly 3 cycles later; DATA reads 0x05; EVENT_COUNT=1.
3. Write IRQ_MASK=0x04 after scenario 2 -> irq=1 on the next cycle. Write EDGE_CAPTURE=0x04 -> irq=0 one cycle later; EDGE_CAPTURE reads 0x01.
4. Clear bit 0 (write 0x01) in the same cycle a new rising edge on bit 0 reaches the detector -> edge_capture[0] stays 1.
5. CNT_WIDTH=4: generate 20 rising edges -> EVENT_COUNT reads 0xF (saturated). Write addr 3 in the same cycle as an edge -> reads 1.
6. EDGE_TYPE=2: toggle bit 7 high then low -> EVENT_COUNT=2. Assert reset_n low mid-sequence -> all registers and irq read 0 immediately, and no spurious edge after release.
